// File: rtl/cnt_arb_pkg.sv
// cnt_arb_pkg: shared definitions for counter_access_arbiter.
//   state_e   - transaction FSM encoding
//   STRB_W    - byte-strobe width of the counter access port
//   to_cnt_w  - width of the issue-phase timeout counter
package cnt_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam int STRB_W = 4;

  // Counter must be able to represent 0..timeout inclusive.
  function automatic int to_cnt_w(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req_i  - request vector
//   ptr_i  - last winner; search starts at ptr_i+1 and wraps modulo N
//   gnt_o  - one-hot grant (zero when no request)
//   idx_o  - index of the granted bit
//   any_o  - at least one request present
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    // i runs 1..N so the previous winner is considered last.
    for (int i = 1; i <= N; i++) begin
      j = (int'(ptr_i) + i) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/counter_access_arbiter.sv
// counter_access_arbiter: shares the counter valid/ready/wstrb port between
// NREQ requesters, round-robin, one transaction at a time.
//   wb_clk_i / wb_rst_ni          - clock, async active-low reset
//   req_valid/ready/we/wstrb/wdata - per-requester request side (packed by index)
//   rsp_valid_o/rsp_rdata_o/rsp_err_o - one-hot response pulse, shared data/error
//   cnt_valid/wstrb/wdata_o, cnt_ready_i, cnt_rdata_i - counter side
//   busy_o, gnt_id_o              - status
// Optional: define CNT_ARB_TIMEOUT_EN to abort a stalled ISSUE after
// TIMEOUT_CYCLES cycles with an error response (rdata forced to 0).
module counter_access_arbiter
  import cnt_arb_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int BITS           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ-1:0]            req_we_i,
  input  logic [STRB_W*NREQ-1:0]     req_wstrb_i,
  input  logic [BITS*NREQ-1:0]       req_wdata_i,
  output logic [NREQ-1:0]            rsp_valid_o,
  output logic [BITS-1:0]            rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic                       cnt_valid_o,
  output logic [STRB_W-1:0]          cnt_wstrb_o,
  output logic [BITS-1:0]            cnt_wdata_o,
  input  logic                       cnt_ready_i,
  input  logic [BITS-1:0]            cnt_rdata_i,
  output logic                       busy_o,
  output logic [$clog2(NREQ)-1:0]    gnt_id_o
);

  localparam int IW     = $clog2(NREQ);
  localparam int NBYTES = (BITS + 7) / 8;
  // Strobes for bytes beyond the data width never reach the counter.
  localparam logic [STRB_W-1:0] STRB_MASK = STRB_W'((1 << NBYTES) - 1);

  state_e              state_q,     state_d;
  logic [IW-1:0]       ptr_q,       ptr_d;
  logic [IW-1:0]       gnt_id_q,    gnt_id_d;
  logic [NREQ-1:0]     req_ready_q, req_ready_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [BITS-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                cnt_valid_q, cnt_valid_d;
  logic [STRB_W-1:0]   cnt_wstrb_q, cnt_wstrb_d;
  logic [BITS-1:0]     cnt_wdata_q, cnt_wdata_d;

  logic [NREQ-1:0]     arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;

`ifdef CNT_ARB_TIMEOUT_EN
  localparam int TO_W = to_cnt_w(TIMEOUT_CYCLES);
  logic [TO_W-1:0]     to_cnt_q,    to_cnt_d;
  logic                rsp_err_q,   rsp_err_d;
`endif

  rr_arbiter #(.N(NREQ)) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    cnt_valid_d = cnt_valid_q;
    cnt_wstrb_d = cnt_wstrb_q;
    cnt_wdata_d = cnt_wdata_q;
`ifdef CNT_ARB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready_d = arb_gnt;
          gnt_id_d    = arb_idx;
          ptr_d       = arb_idx;
          // Read/write folded into the strobes: a read issues none.
          cnt_wstrb_d = req_wstrb_i[STRB_W*arb_idx +: STRB_W]
                        & {STRB_W{req_we_i[arb_idx]}} & STRB_MASK;
          cnt_wdata_d = req_wdata_i[BITS*arb_idx +: BITS];
          state_d     = ST_ISSUE;
`ifdef CNT_ARB_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end
      end
      ST_ISSUE: begin
        // First ISSUE cycle is the grant cycle; the request goes out after it.
        // Acks are only meaningful while cnt_valid_o is up.
        if (!cnt_valid_q) begin
          cnt_valid_d = 1'b1;
        end else if (cnt_ready_i) begin
          cnt_valid_d           = 1'b0;
          rsp_rdata_d           = cnt_rdata_i;
          rsp_valid_d[gnt_id_q] = 1'b1;
          state_d               = ST_RESP;
`ifdef CNT_ARB_TIMEOUT_EN
          rsp_err_d             = 1'b0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Ack in the expiring cycle is taken by the branch above.
          cnt_valid_d           = 1'b0;
          rsp_rdata_d           = '0;
          rsp_err_d             = 1'b1;
          rsp_valid_d[gnt_id_q] = 1'b1;
          state_d               = ST_RESP;
        end else begin
          to_cnt_d              = to_cnt_q + 1'b1;
`endif
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IW'(NREQ - 1);
      gnt_id_q    <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      cnt_valid_q <= 1'b0;
      cnt_wstrb_q <= '0;
      cnt_wdata_q <= '0;
`ifdef CNT_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_valid_q <= cnt_valid_d;
      cnt_wstrb_q <= cnt_wstrb_d;
      cnt_wdata_q <= cnt_wdata_d;
`ifdef CNT_ARB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign cnt_valid_o = cnt_valid_q;
  assign cnt_wstrb_o = cnt_wstrb_q;
  assign cnt_wdata_o = cnt_wdata_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign gnt_id_o    = gnt_id_q;
`ifdef CNT_ARB_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Bench for counter_access_arbiter: table-driven single-requester vectors,
// plus sequences for round-robin order, withdraw, mid-flight reset and the
// optional timeout. Expected responses go through a scoreboard queue.
module tb_counter_access_arbiter;
  localparam int NREQ = 3;
  localparam int BITS = 32;
  localparam int TO   = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid_i = '0;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ-1:0]      req_we_i = '0;
  logic [4*NREQ-1:0]    req_wstrb_i = '0;
  logic [BITS*NREQ-1:0] req_wdata_i = '0;
  logic [NREQ-1:0]      rsp_valid_o;
  logic [BITS-1:0]      rsp_rdata_o;
  logic                 rsp_err_o;
  logic                 cnt_valid_o;
  logic [3:0]           cnt_wstrb_o;
  logic [BITS-1:0]      cnt_wdata_o;
  logic                 cnt_ready_i = 1'b0;
  logic [BITS-1:0]      cnt_rdata_i = '0;
  logic                 busy_o;
  logic [1:0]           gnt_id_o;

  always #5 clk = ~clk;

  counter_access_arbiter #(.NREQ(NREQ), .BITS(BITS), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_wstrb_i(req_wstrb_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .cnt_valid_o(cnt_valid_o), .cnt_wstrb_o(cnt_wstrb_o), .cnt_wdata_o(cnt_wdata_o),
    .cnt_ready_i(cnt_ready_i), .cnt_rdata_i(cnt_rdata_i),
    .busy_o(busy_o), .gnt_id_o(gnt_id_o)
  );

  typedef struct {
    int          id;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic [3:0]  exp_strb;
  } vec_t;

  typedef struct {
    logic [NREQ-1:0] oh;
    logic [31:0]     rdata;
    logic            err;
  } rsp_t;

  rsp_t sb[$];
  vec_t vecs[5];
  int   vec_n = 0;
  int   miss  = 0;

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    vec_n++;
    miss++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Compare the response currently on the outputs against the scoreboard head.
  task automatic expect_rsp();
    rsp_t e;
    if (sb.size() == 0) begin
      bound_fail("rsp_no_expectation");
      return;
    end
    e = sb.pop_front();
    chk("rsp_valid", 64'(rsp_valid_o), 64'(e.oh));
    chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
    chk("rsp_err",   64'(rsp_err_o),   64'(e.err));
  endtask

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready_o != '0) begin
        ok = 1'b1;
        return;
      end
    end
    bound_fail("req_ready_wait");
  endtask

  // Called at the negedge of the first cnt_valid_o cycle.
  task automatic ack(input logic [31:0] rd, input int dly, input int id);
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      chk("cnt_valid_hold", 64'(cnt_valid_o), 64'(1));
    end
    cnt_ready_i = 1'b1;
    cnt_rdata_i = rd;
    sb.push_back('{oh(id), rd, 1'b0});
    @(negedge clk);
    cnt_ready_i = 1'b0;
    cnt_rdata_i = '0;
    chk("cnt_valid_drop", 64'(cnt_valid_o), 64'(0));
    expect_rsp();
  endtask

  task automatic drive_req(input int id, input logic we, input logic [3:0] strb,
                           input logic [31:0] wd);
    req_valid_i[id]           = 1'b1;
    req_we_i[id]              = we;
    req_wstrb_i[4*id +: 4]    = strb;
    req_wdata_i[32*id +: 32]  = wd;
  endtask

  task automatic run_vec(input vec_t v);
    logic ok;
    @(negedge clk);
    drive_req(v.id, v.we, v.strb, v.wdata);
    wait_ready(ok);
    if (!ok) begin
      req_valid_i = '0;
      return;
    end
    chk("req_ready", 64'(req_ready_o), 64'(oh(v.id)));
    chk("gnt_id",    64'(gnt_id_o),    64'(v.id));
    req_valid_i[v.id] = 1'b0;
    @(negedge clk);
    chk("cnt_valid_lat", 64'(cnt_valid_o), 64'(1));
    chk("cnt_wstrb",     64'(cnt_wstrb_o), 64'(v.exp_strb));
    chk("cnt_wdata",     64'(cnt_wdata_o), 64'(v.wdata));
    chk("busy",          64'(busy_o),      64'(1));
    ack(v.rdata, v.dly, v.id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    //            id we strb     wdata          rdata          dly exp_strb
    vecs[0] = '{1, 1'b1, 4'b0011, 32'h0000_ABCD, 32'h0000_1111, 2, 4'b0011};
    vecs[1] = '{0, 1'b0, 4'hF,    32'h1234_5678, 32'h0000_0042, 0, 4'b0000};
    vecs[2] = '{2, 1'b1, 4'hF,    32'hDEAD_BEEF, 32'h0000_0000, 1, 4'hF};
    vecs[3] = '{0, 1'b1, 4'b1000, 32'hCAFE_0001, 32'h8000_0001, 3, 4'b1000};
    vecs[4] = '{2, 1'b0, 4'b0101, 32'h5555_AAAA, 32'hFFFF_FFFF, 0, 4'b0000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready_o), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata_o), 64'(0));
    chk("rst_cnt_valid", 64'(cnt_valid_o), 64'(0));
    chk("rst_busy",      64'(busy_o),      64'(0));
    chk("rst_gnt_id",    64'(gnt_id_o),    64'(0));
    rst_n = 1'b1;

    // Round-robin under continuous requests from everyone
    @(negedge clk);
    for (int r = 0; r < NREQ; r++) drive_req(r, 1'b0, 4'hF, 32'h100 + 32'(r));
    for (int k = 0; k < 4; k++) begin
      wait_ready(ok);
      if (!ok) break;
      chk("rr_ready", 64'(req_ready_o), 64'(oh(k % NREQ)));
      if (k == 3) req_valid_i = '0;
      @(negedge clk);
      chk("rr_cnt_valid", 64'(cnt_valid_o), 64'(1));
      ack(32'h200 + 32'(k), 0, k % NREQ);
    end
    req_valid_i = '0;

    // Table vectors
    foreach (vecs[i]) run_vec(vecs[i]);

    // Requester 2 requests then withdraws while requester 0 is in flight
    @(negedge clk);
    drive_req(0, 1'b0, 4'hF, 32'h0);
    wait_ready(ok);
    if (ok) begin
      chk("wd_ready0", 64'(req_ready_o), 64'(oh(0)));
      req_valid_i[0] = 1'b0;
      @(negedge clk);
      req_valid_i[2] = 1'b1;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk("wd_no_ready", 64'(req_ready_o), 64'(0));
      end
      req_valid_i[2] = 1'b0;
      ack(32'h0000_0777, 1, 0);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        chk("wd_idle_ready", 64'(req_ready_o), 64'(0));
        chk("wd_idle_rsp",   64'(rsp_valid_o), 64'(0));
      end
    end
    req_valid_i = '0;

    // Reset while in ISSUE drops the transaction
    @(negedge clk);
    drive_req(1, 1'b1, 4'hF, 32'h1357_9BDF);
    wait_ready(ok);
    req_valid_i = '0;
    @(negedge clk);
    chk("pre_rst_cnt_valid", 64'(cnt_valid_o), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt_valid", 64'(cnt_valid_o), 64'(0));
    chk("mid_rst_wdata",     64'(cnt_wdata_o), 64'(0));
    chk("mid_rst_wstrb",     64'(cnt_wstrb_o), 64'(0));
    chk("mid_rst_rdata",     64'(rsp_rdata_o), 64'(0));
    chk("mid_rst_busy",      64'(busy_o),      64'(0));
    chk("mid_rst_gnt_id",    64'(gnt_id_o),    64'(0));
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_rsp", 64'(rsp_valid_o), 64'(0));
    end
    rst_n = 1'b1;
    for (int r = 0; r < NREQ; r++) drive_req(r, 1'b0, 4'hF, 32'h0);
    wait_ready(ok);
    if (ok) begin
      chk("post_rst_ready", 64'(req_ready_o), 64'(oh(0)));
      req_valid_i = '0;
      @(negedge clk);
      ack(32'h0000_0ABC, 0, 0);
    end
    req_valid_i = '0;

`ifdef CNT_ARB_TIMEOUT_EN
    // Stalled counter: cnt_valid_o must stay up for exactly TO cycles
    begin
      int n;
      @(negedge clk);
      drive_req(0, 1'b1, 4'hF, 32'h0BAD_0BAD);
      wait_ready(ok);
      req_valid_i = '0;
      @(negedge clk);
      n = 0;
      while (cnt_valid_o && n < 4 * TO) begin
        n++;
        @(negedge clk);
      end
      chk("to_cycles", 64'(n), 64'(TO));
      sb.push_back('{oh(0), 32'h0, 1'b1});
      expect_rsp();
    end
    run_vec(vecs[1]);
`endif

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss);
    $finish;
  end

endmodule

// File: doc/counter_access_arbiter.md
Name: counter_access_arbiter

Overview:
Shares the single valid/ready/wstrb access port of the project counter between NREQ independent requesters, such as the Wishbone slave, the LA control path and an on-chip sequencer. It grants requesters round-robin and issues exactly one counter transaction at a time. It returns each transaction's read data, and optionally an error, only to the granted requester. It sits between the requester front-ends and the counter in the user project area.

Parameters:
NREQ, 3, number of requesters (2..8)
BITS, 32, counter data width (8..32)
TIMEOUT_CYCLES, 16, max cycles to wait for cnt_ready_i (used only with the optional feature)

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NREQ  per-requester request
req_ready_o  out  NREQ  one-hot single-cycle accept pulse
req_we_i  in  NREQ  per-requester write enable
req_wstrb_i  in  4*NREQ  byte strobes, requester r at [4r+3:4r]
req_wdata_i  in  BITS*NREQ  write data, requester r at [BITS*r+BITS-1:BITS*r]
rsp_valid_o  out  NREQ  one-hot single-cycle response pulse
rsp_rdata_o  out  BITS  response data (shared, qualified by rsp_valid_o)
rsp_err_o  out  1  response error (qualified by any rsp_valid_o)
cnt_valid_o  out  1  transaction request to the counter
cnt_wstrb_o  out  4  strobes to the counter
cnt_wdata_o  out  BITS  write data to the counter
cnt_ready_i  in  1  counter acknowledge (single-cycle pulse)
cnt_rdata_i  in  BITS  counter value sampled at acknowledge
busy_o  out  1  transaction in flight (state != IDLE)
gnt_id_o  out  $clog2(NREQ)  index of the current or last granted requester

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All outputs are 0.
  - State is IDLE; RR pointer is NREQ-1, so requester 0 wins first.
  - A reset mid-transaction drops the transaction with no response.
- FSM states: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE:
  - If any req_valid_i is high, pick the first set bit starting at pointer+1 and wrapping modulo NREQ.
  - Latch we, wstrb and wdata for the winner.
  - Pulse req_ready_o[g] for 1 cycle, set gnt_id_o=g, set pointer=g, and go to ISSUE.
- ISSUE:
  - cnt_valid_o=1 from the cycle after the grant and held until cnt_ready_i is seen.
  - cnt_wstrb_o = latched wstrb & {4{we}}, so a read issues 0 strobes.
  - cnt_wdata_o = latched wdata.
  - On cnt_ready_i: capture cnt_rdata_i into rsp_rdata_o, drop cnt_valid_o on the next edge, and go to RESP.
- RESP:
  - rsp_valid_o[g]=1 for exactly 1 cycle, then return to IDLE.
  - rsp_rdata_o holds its value until the next response.
- Latency and throughput:
  - Grant to cnt_valid_o is 1 cycle; cnt_ready_i to rsp_valid_o is 1 cycle.
  - The minimum grant-to-grant spacing is 4 cycles with a 1-cycle counter.
- Requester rules:
  - req_valid_i and its payload must be held until req_ready_o.
  - Deasserting req_valid_i before the grant is legal and is simply ignored.
- Simultaneous requests:
  - Exactly one grant per IDLE cycle.
  - Under continuous requests from all requesters, grant order is 0,1,...,NREQ-1,0.
- Non-granted requesters see no change while a transaction is in flight. Requests arriving in ISSUE or RESP wait.
- A cnt_ready_i seen in IDLE or RESP is ignored.
- Width rules:
  - For BITS<32, strobes above byte ceil(BITS/8)-1 are forced to 0.
  - The read data is passed through unmodified at BITS width.

Optional Feature:
Macro CNT_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ISSUE. When TIMEOUT_CYCLES cycles pass without cnt_ready_i, cnt_valid_o drops and the FSM enters RESP.
  - The response is rsp_err_o=1 with rsp_rdata_o=0.
  - A normal completion gives rsp_err_o=0.
  - If cnt_ready_i arrives in the same cycle the timeout expires, it wins and is a normal completion.
- Undefined: no cycle counter is built, ISSUE waits indefinitely, and rsp_err_o is tied to 0.

Decomposition:
- Package cnt_arb_pkg:
  - FSM state encoding (IDLE/ISSUE/RESP).
  - STRB_W=4 constant.
  - Timeout counter width function clog2(TIMEOUT_CYCLES+1).
- Sub-module rr_arbiter:
  - Combinational: req vector plus pointer in, one-hot grant plus index out.
  - Reused by other shared-resource blocks in the user area.

Test Plan:
- Reset with req_valid_i=3'b111 then release → grants 0,1,2,0 in successive transactions; req_ready_o pulses 3'b001, 3'b010, 3'b100.
- Req1 write, we=1, wstrb=4'b0011, wdata=32'h0000_ABCD; counter acks 2 cycles after cnt_valid_o → cnt_wstrb_o=4'b0011, cnt_wdata_o=32'hABCD; rsp_valid_o=3'b010 1 cycle after ack.
- Req0 read, we=0, wstrb=4'hF, counter returns 32'h0000_0042 → cnt_wstrb_o=4'b0000, rsp_rdata_o=32'h42, rsp_err_o=0.
- Assert wb_rst_ni=0 while in ISSUE → all outputs 0 immediately with no rsp_valid_o; the next grant after release goes to requester 0.
- CNT_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and cnt_ready_i stuck at 0 → cnt_valid_o drops after 16 cycles; rsp_valid_o pulses with rsp_err_o=1 and rsp_rdata_o=0.
- Requester 2 asserts then withdraws req_valid_i while requester 0 is in flight → no grant or response to requester 2.
